// File: rtl/imem_dmem_arbiter_if.sv
// rtl/imem_dmem_arbiter_if.sv - core-side I/D request ports and unified memory port bundle
interface imem_dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - shares one synchronous memory port between fetch (I) and load/store (D)
module imem_dmem_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_WAIT    = 3
) (
  input logic                  clk,
  input logic                  reset,
  imem_dmem_arbiter_if.slave   bus
);
  logic                   w_starve;
  logic                   w_i_gnt;
  logic                   w_d_gnt;
  logic                   w_push_v;
  logic [3:0]             r_wait_cnt;
  logic [MEM_LATENCY-1:0] r_tag_v;
  logic [MEM_LATENCY-1:0] r_tag_own;

  assign w_starve = (r_wait_cnt == 4'(MAX_WAIT));

  // D normally wins; a fetch that has been denied MAX_WAIT cycles in a row takes the slot.
  always_comb begin
    w_i_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (!reset) begin
      if (bus.i_req && (w_starve || !bus.d_req)) begin
        w_i_gnt = 1'b1;
      end else if (bus.d_req) begin
        w_d_gnt = 1'b1;
      end
    end
  end

  assign bus.i_gnt     = w_i_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.mem_en    = w_i_gnt | w_d_gnt;
  assign bus.mem_we    = w_d_gnt & bus.d_we;
  assign bus.mem_addr  = w_i_gnt ? bus.i_addr : (w_d_gnt ? bus.d_addr : '0);
  assign bus.mem_wdata = w_d_gnt ? bus.d_wdata : '0;

  assign w_push_v = (w_i_gnt | w_d_gnt) & ~(w_d_gnt & bus.d_we);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= 4'd0;
    end else if (!bus.i_req || w_i_gnt) begin
      r_wait_cnt <= 4'd0;
    end else if (!w_starve) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // Stage 0 holds the tag of this cycle's access; the last stage lines up with mem_rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_v   <= '0;
      r_tag_own <= '0;
    end else begin
      r_tag_v[0]   <= w_push_v;
      r_tag_own[0] <= w_i_gnt;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        r_tag_v[k]   <= r_tag_v[k-1];
        r_tag_own[k] <= r_tag_own[k-1];
      end
    end
  end

  assign bus.i_rvalid = ~reset & r_tag_v[MEM_LATENCY-1] &  r_tag_own[MEM_LATENCY-1];
  assign bus.d_rvalid = ~reset & r_tag_v[MEM_LATENCY-1] & ~r_tag_own[MEM_LATENCY-1];
  assign bus.i_rdata  = bus.mem_rdata;
  assign bus.d_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb/tb_imem_dmem_arbiter.sv - randomized bench for imem_dmem_arbiter at MEM_LATENCY 1 and 3
module tb_imem_dmem_arbiter;
  localparam int MAX_WAIT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_rst = 1'b1;
  logic        s_ireq = 1'b0;
  logic [31:0] s_iaddr = '0;
  logic        s_dreq = 1'b0;
  logic        s_dwe = 1'b0;
  logic [31:0] s_daddr = '0;
  logic [31:0] s_dwdata = '0;

  imem_dmem_arbiter_if #(.AW(32), .DW(32)) b1 ();
  imem_dmem_arbiter_if #(.AW(32), .DW(32)) b3 ();

  assign b1.i_req = s_ireq;  assign b3.i_req = s_ireq;
  assign b1.i_addr = s_iaddr; assign b3.i_addr = s_iaddr;
  assign b1.d_req = s_dreq;  assign b3.d_req = s_dreq;
  assign b1.d_we = s_dwe;    assign b3.d_we = s_dwe;
  assign b1.d_addr = s_daddr; assign b3.d_addr = s_daddr;
  assign b1.d_wdata = s_dwdata; assign b3.d_wdata = s_dwdata;

  imem_dmem_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(1), .MAX_WAIT(MAX_WAIT)) dut1 (
    .clk(clk), .reset(s_rst), .bus(b1)
  );
  imem_dmem_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(3), .MAX_WAIT(MAX_WAIT)) dut3 (
    .clk(clk), .reset(s_rst), .bus(b3)
  );

  function automatic logic [31:0] init_word(input logic [7:0] i);
    return 32'hC0DE_0000 ^ {i, ~i, i, i ^ 8'h5A};
  endfunction

  // Memory environment: 256 words, unwritten words read back as init_word, cleared on reset.
  logic [31:0]  mem1 [256];
  logic [255:0] wv1;
  logic [31:0]  rp1;
  logic [31:0]  mem3 [256];
  logic [255:0] wv3;
  logic [31:0]  rp3 [3];

  always @(posedge clk) begin
    if (s_rst) begin
      wv1 <= '0;
    end else if (b1.mem_en && b1.mem_we) begin
      mem1[b1.mem_addr[9:2]] <= b1.mem_wdata;
      wv1[b1.mem_addr[9:2]]  <= 1'b1;
    end
    rp1 <= wv1[b1.mem_addr[9:2]] ? mem1[b1.mem_addr[9:2]] : init_word(b1.mem_addr[9:2]);
  end
  assign b1.mem_rdata = rp1;

  always @(posedge clk) begin
    if (s_rst) begin
      wv3 <= '0;
    end else if (b3.mem_en && b3.mem_we) begin
      mem3[b3.mem_addr[9:2]] <= b3.mem_wdata;
      wv3[b3.mem_addr[9:2]]  <= 1'b1;
    end
    rp3[0] <= wv3[b3.mem_addr[9:2]] ? mem3[b3.mem_addr[9:2]] : init_word(b3.mem_addr[9:2]);
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign b3.mem_rdata = rp3[2];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference: reads logged in issue order; each instance consumes the log at its own latency.
  int          lat [2] = '{1, 3};
  int          hd [2] = '{0, 0};
  int          rd_cyc [$];
  bit          rd_own [$];
  logic [31:0] rd_data [$];
  logic [31:0] ref_mem [256];
  bit          ref_wv [256];
  int          ref_wait = 0;

  logic        o_ig [2], o_dg [2], o_en [2], o_we [2], o_iv [2], o_dv [2];
  logic [31:0] o_addr [2], o_wd [2], o_ird [2], o_drd [2];

  task automatic run_cycle(input bit rst, input bit ir, input logic [31:0] ia,
                           input bit dr, input bit dwe, input logic [31:0] da,
                           input logic [31:0] dwd, output bit eig, output bit edg);
    bit          e_we, ev_i, ev_d;
    logic [31:0] e_addr, e_wd, ed;
    logic [7:0]  idx;
    string       pfx;
    @(posedge clk);
    #1;
    s_rst = rst; s_ireq = ir; s_iaddr = ia;
    s_dreq = dr; s_dwe = dwe; s_daddr = da; s_dwdata = dwd;
    @(negedge clk);
    o_ig[0] = b1.i_gnt; o_dg[0] = b1.d_gnt; o_en[0] = b1.mem_en; o_we[0] = b1.mem_we;
    o_addr[0] = b1.mem_addr; o_wd[0] = b1.mem_wdata; o_iv[0] = b1.i_rvalid; o_dv[0] = b1.d_rvalid;
    o_ird[0] = b1.i_rdata; o_drd[0] = b1.d_rdata;
    o_ig[1] = b3.i_gnt; o_dg[1] = b3.d_gnt; o_en[1] = b3.mem_en; o_we[1] = b3.mem_we;
    o_addr[1] = b3.mem_addr; o_wd[1] = b3.mem_wdata; o_iv[1] = b3.i_rvalid; o_dv[1] = b3.d_rvalid;
    o_ird[1] = b3.i_rdata; o_drd[1] = b3.d_rdata;

    eig    = !rst && ir && (!dr || ref_wait == MAX_WAIT);
    edg    = !rst && dr && !eig;
    e_we   = edg && dwe;
    e_addr = eig ? ia : (edg ? da : 32'h0);
    e_wd   = edg ? dwd : 32'h0;
    if (rst) begin
      hd[0] = rd_cyc.size();
      hd[1] = rd_cyc.size();
      for (int i = 0; i < 256; i++) ref_wv[i] = 1'b0;
    end

    for (int k = 0; k < 2; k++) begin
      pfx = $sformatf("ml%0d_", lat[k]);
      check({pfx, "i_gnt"}, 64'(o_ig[k]), 64'(eig));
      check({pfx, "d_gnt"}, 64'(o_dg[k]), 64'(edg));
      check({pfx, "mem_en"}, 64'(o_en[k]), 64'(eig | edg));
      check({pfx, "mem_we"}, 64'(o_we[k]), 64'(e_we));
      check({pfx, "mem_addr"}, 64'(o_addr[k]), 64'(e_addr));
      check({pfx, "mem_wdata"}, 64'(o_wd[k]), 64'(e_wd));
      ev_i = 1'b0; ev_d = 1'b0; ed = '0;
      if (!rst && hd[k] < rd_cyc.size() && rd_cyc[hd[k]] + lat[k] == cyc) begin
        ev_i = rd_own[hd[k]];
        ev_d = !rd_own[hd[k]];
        ed   = rd_data[hd[k]];
        hd[k]++;
      end
      check({pfx, "i_rvalid"}, 64'(o_iv[k]), 64'(ev_i));
      check({pfx, "d_rvalid"}, 64'(o_dv[k]), 64'(ev_d));
      if (ev_i) check({pfx, "i_rdata"}, 64'(o_ird[k]), 64'(ed));
      if (ev_d) check({pfx, "d_rdata"}, 64'(o_drd[k]), 64'(ed));
    end

    idx = e_addr[9:2];
    if (eig || (edg && !dwe)) begin
      rd_cyc.push_back(cyc);
      rd_own.push_back(eig);
      rd_data.push_back(ref_wv[idx] ? ref_mem[idx] : init_word(idx));
    end
    if (e_we) begin
      ref_mem[idx] = dwd;
      ref_wv[idx]  = 1'b1;
    end
    if (!rst && ir && !eig) ref_wait = (ref_wait < MAX_WAIT) ? ref_wait + 1 : MAX_WAIT;
    else ref_wait = 0;
    cyc++;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 31)) << 2;
  endfunction

  bit          gi, gd, ip, dp, dwe_p, rst_p;
  logic [31:0] ia_p, da_p, dwd_p;

  initial begin
    for (int i = 0; i < 256; i++) ref_wv[i] = 1'b0;
    // reset with both requests pending: nothing may be granted
    repeat (2) run_cycle(1, 1, 32'h4, 1, 1, 32'h8, 32'h1234, gi, gd);
    // fetch-only burst
    for (int i = 0; i < 4; i++) run_cycle(0, 1, 32'(i * 4), 0, 0, 0, 0, gi, gd);
    repeat (4) run_cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);
    // collision: load 0x100 beats fetch, fetch follows
    run_cycle(0, 1, 32'h10, 1, 0, 32'h100, 0, gi, gd);
    run_cycle(0, 1, 32'h10, 0, 0, 0, 0, gi, gd);
    repeat (4) run_cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);
    // D hammering continuously while one fetch waits, then a fresh fetch
    ia_p = 32'h20;
    for (int i = 0; i < 12; i++) begin
      run_cycle(0, 1, ia_p, 1, 0, rand_addr(), 32'h0, gi, gd);
      if (gi) ia_p = ia_p + 32'h4;
    end
    repeat (4) run_cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);
    // store then load of 0x200
    run_cycle(0, 0, 0, 1, 1, 32'h200, 32'hDEADBEEF, gi, gd);
    run_cycle(0, 0, 0, 1, 0, 32'h200, 32'h0, gi, gd);
    repeat (4) run_cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);
    // alternating I/D reads back to back
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) run_cycle(0, 1, 32'(i * 8), 0, 0, 0, 0, gi, gd);
      else            run_cycle(0, 0, 0, 1, 0, 32'(32'h200 + i * 4), 0, gi, gd);
    end
    repeat (4) run_cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);
    // two reads in flight, then reset
    run_cycle(0, 1, 32'h40, 0, 0, 0, 0, gi, gd);
    run_cycle(0, 0, 0, 1, 0, 32'h44, 0, gi, gd);
    run_cycle(1, 1, 32'h48, 1, 0, 32'h4C, 0, gi, gd);
    run_cycle(1, 1, 32'h48, 1, 0, 32'h4C, 0, gi, gd);
    run_cycle(0, 1, 32'h48, 0, 0, 0, 0, gi, gd);
    repeat (4) run_cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);

    // random traffic with occasional abandoned requests and resets
    ip = 0; dp = 0; dwe_p = 0; ia_p = 0; da_p = 0; dwd_p = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!ip && $urandom_range(0, 3) != 0) begin
        ip = 1; ia_p = rand_addr();
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1; dwe_p = ($urandom_range(0, 3) == 0); da_p = rand_addr(); dwd_p = $urandom;
      end
      if (ip && $urandom_range(0, 19) == 0) ip = 0;
      if (dp && $urandom_range(0, 19) == 0) dp = 0;
      rst_p = ($urandom_range(0, 99) == 0);
      run_cycle(rst_p, ip, ia_p, dp, dwe_p, da_p, dwd_p, gi, gd);
      if (gi) ip = 0;
      if (gd) dp = 0;
    end
    repeat (5) run_cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
